// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// Holds the FSM state encoding, the grant encoding (which requester owns the
// current access) and the width of the wait-cycle down-counter.
package mem_arb_pkg;

   // Arbiter FSM states: waiting, driving the memory port, reporting completion
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_DONE
   } state_t;

   // Owner of the access currently in flight
   typedef enum logic {
      GNT_IF,
      GNT_DM
   } grant_t;

   // Wait-cycle counter width; covers WAIT_CYCLES values 0..15
   localparam int CNT_W = 4;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter that times the memory access window.
// It is loaded with the number of extra wait cycles when an access starts and
// counts down while the port is busy; the zero flag marks the final cycle.
module mem_wait_counter
   import mem_arb_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_loadValue,
   input  logic             i_dec,
   output logic [CNT_W-1:0] o_count,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_count;

   // Load takes precedence over decrement, and the count saturates at zero
   // so it can never wrap around.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_loadValue;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - CNT_W'(1);
      end
   end

   assign o_count = r_count;
   assign o_zero  = (r_count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and load/store.
// A winner is chosen in IDLE and its request is latched. The port is then
// driven for WAIT_CYCLES+1 cycles, and a one-cycle done pulse follows.
// Read data is captured into the winner's rdata register in the last access
// cycle, together with the MDR load strobe.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration on
// conflicts. With it undefined, dm always beats if.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_done,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_done,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mdr_load,
   output logic              busy
);

   state_t            r_state;
   state_t            w_nextState;
   grant_t            r_grant;
   grant_t            w_winner;
   logic              w_start;
   logic              w_inAccess;
   logic              w_mdrLoad;
   logic [ADDR_W-1:0] r_addr;
   logic              r_we;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_ifRdata;
   logic [DATA_W-1:0] r_dmRdata;
   logic [CNT_W-1:0]  w_count;
   logic              w_zero;

`ifdef MEM_ARB_RR_EN
   grant_t            r_lastGrant;

   // Remember who won the most recent conflict. Starting at dm means the
   // first conflict goes to if. Lone requests leave this untouched, so
   // grants alternate strictly from one conflict to the next.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lastGrant <= GNT_DM;
      end else if (w_start && if_req && dm_req) begin
         r_lastGrant <= w_winner;
      end
   end
`endif

   // Pick the requester to serve. A lone request always wins. On a conflict,
   // dm wins, unless round-robin is enabled, in which case the loser of the
   // previous conflict wins.
   always_comb begin
      w_winner = GNT_IF;
      if (if_req && dm_req) begin
`ifdef MEM_ARB_RR_EN
         if (r_lastGrant == GNT_DM) begin
            w_winner = GNT_IF;
         end else begin
            w_winner = GNT_DM;
         end
`else
         w_winner = GNT_DM;
`endif
      end else if (dm_req) begin
         w_winner = GNT_DM;
      end
   end

   // State register for the access sequencer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. The counter reaching zero inside ACCESS marks the
   // final memory cycle. DONE always returns to IDLE, so back-to-back
   // requests see one idle cycle.
   always_comb begin
      w_nextState = r_state;
      w_start     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (if_req || dm_req) begin
               w_nextState = ST_ACCESS;
               w_start     = 1'b1;
            end
         end
         ST_ACCESS: begin
            if (w_zero) begin
               w_nextState = ST_DONE;
            end
         end
         ST_DONE: begin
            w_nextState = ST_IDLE;
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   assign w_inAccess = (r_state == ST_ACCESS);
   assign w_mdrLoad  = w_inAccess && w_zero && !r_we;

   mem_wait_counter u_waitCounter (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_load      (w_start),
      .i_loadValue (CNT_W'(WAIT_CYCLES)),
      .i_dec       (w_inAccess),
      .o_count     (w_count),
      .o_zero      (w_zero)
   );

   // Latch the winner's request when the access starts. Requester inputs
   // are ignored after this point. A fetch leaves the store data alone, so
   // mem_wdata keeps showing the last store.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_grant <= GNT_IF;
         r_addr  <= '0;
         r_we    <= 1'b0;
         r_wdata <= '0;
      end else if (w_start) begin
         r_grant <= w_winner;
         if (w_winner == GNT_DM) begin
            r_addr  <= dm_addr;
            r_we    <= dm_we;
            r_wdata <= dm_wdata;
         end else begin
            r_addr  <= if_addr;
            r_we    <= 1'b0;
         end
      end
   end

   // Capture returned read data into the owner's rdata register in the last
   // access cycle. Each register holds its value until that requester's next
   // read completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ifRdata <= '0;
         r_dmRdata <= '0;
      end else if (w_mdrLoad) begin
         if (r_grant == GNT_IF) begin
            r_ifRdata <= mem_rdata;
         end else begin
            r_dmRdata <= mem_rdata;
         end
      end
   end

   assign mem_en    = w_inAccess;
   assign mem_we    = w_inAccess && r_we;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign mdr_load  = w_mdrLoad;
   assign busy      = (r_state != ST_IDLE);
   assign if_done   = (r_state == ST_DONE) && (r_grant == GNT_IF);
   assign dm_done   = (r_state == ST_DONE) && (r_grant == GNT_DM);
   assign if_rdata  = r_ifRdata;
   assign dm_rdata  = r_dmRdata;

   logic [CNT_W-1:0] w_countUnused;
   assign w_countUnused = w_count;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter.
// Instance A uses WAIT_CYCLES=2 and covers fetch, store, conflict and
// mid-access reset. Instance B uses WAIT_CYCLES=0 for the single-cycle load.
// Conflict ordering follows MEM_ARB_RR_EN when that macro is defined.
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst_n;

   logic        ifReqA, ifDoneA, dmReqA, dmWeA, dmDoneA;
   logic        memEnA, memWeA, mdrLoadA, busyA;
   logic [31:0] ifAddrA, ifRdataA, dmAddrA, dmWdataA, dmRdataA;
   logic [31:0] memAddrA, memWdataA, memRdataA;

   logic        ifReqB, ifDoneB, dmReqB, dmWeB, dmDoneB;
   logic        memEnB, memWeB, mdrLoadB, busyB;
   logic [31:0] ifAddrB, ifRdataB, dmAddrB, dmWdataB, dmRdataB;
   logic [31:0] memAddrB, memWdataB, memRdataB;

   int          checks = 0;
   int          errors = 0;
   bit          firstDm;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(2)) dutA (
      .clk(clk), .rst_n(rst_n),
      .if_req(ifReqA), .if_addr(ifAddrA), .if_done(ifDoneA), .if_rdata(ifRdataA),
      .dm_req(dmReqA), .dm_we(dmWeA), .dm_addr(dmAddrA), .dm_wdata(dmWdataA),
      .dm_done(dmDoneA), .dm_rdata(dmRdataA),
      .mem_en(memEnA), .mem_we(memWeA), .mem_addr(memAddrA), .mem_wdata(memWdataA),
      .mem_rdata(memRdataA), .mdr_load(mdrLoadA), .busy(busyA)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0)) dutB (
      .clk(clk), .rst_n(rst_n),
      .if_req(ifReqB), .if_addr(ifAddrB), .if_done(ifDoneB), .if_rdata(ifRdataB),
      .dm_req(dmReqB), .dm_we(dmWeB), .dm_addr(dmAddrB), .dm_wdata(dmWdataB),
      .dm_done(dmDoneB), .dm_rdata(dmRdataB),
      .mem_en(memEnB), .mem_we(memWeB), .mem_addr(memAddrB), .mem_wdata(memWdataB),
      .mem_rdata(memRdataB), .mdr_load(mdrLoadB), .busy(busyB)
   );

   // 10 ns clock shared by both instances
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the run always ends even if the sequence stalls
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Compare one observed value against its hand-computed expectation
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
   endtask

   // Advance to just after the next rising edge: drive and sample here
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   // Linear sequence of directed steps
   initial begin
      rst_n = 1'b0;
      ifReqA = 0; ifAddrA = '0; dmReqA = 0; dmWeA = 0; dmAddrA = '0; dmWdataA = '0; memRdataA = '0;
      ifReqB = 0; ifAddrB = '0; dmReqB = 0; dmWeB = 0; dmAddrB = '0; dmWdataB = '0; memRdataB = '0;
`ifdef MEM_ARB_RR_EN
      firstDm = 1'b0;
`else
      firstDm = 1'b1;
`endif

      // Reset state
      #2;
      checkOutput("reset_busy",    busyA,    0);
      checkOutput("reset_memEn",   memEnA,   0);
      checkOutput("reset_ifDone",  ifDoneA,  0);
      checkOutput("reset_memAddr", memAddrA, 0);
      checkOutput("reset_ifRdata", ifRdataA, 0);
      checkOutput("reset_dmRdata", dmRdataA, 0);
      #6 rst_n = 1'b1;
      applyStimulus();

      // Fetch from 0x40 with WAIT_CYCLES=2
      ifReqA = 1; ifAddrA = 32'h0000_0040; memRdataA = 32'h8C01_0004;
      applyStimulus();
      checkOutput("fetch_acc1_memEn",   memEnA,   1);
      checkOutput("fetch_acc1_memAddr", memAddrA, 32'h0000_0040);
      checkOutput("fetch_acc1_memWe",   memWeA,   0);
      checkOutput("fetch_acc1_mdrLoad", mdrLoadA, 0);
      checkOutput("fetch_acc1_busy",    busyA,    1);
      applyStimulus();
      checkOutput("fetch_acc2_memEn",   memEnA,   1);
      checkOutput("fetch_acc2_mdrLoad", mdrLoadA, 0);
      applyStimulus();
      checkOutput("fetch_acc3_memEn",   memEnA,   1);
      checkOutput("fetch_acc3_mdrLoad", mdrLoadA, 1);
      checkOutput("fetch_acc3_ifDone",  ifDoneA,  0);
      applyStimulus();
      checkOutput("fetch_done_ifDone",  ifDoneA,  1);
      checkOutput("fetch_done_dmDone",  dmDoneA,  0);
      checkOutput("fetch_done_ifRdata", ifRdataA, 32'h8C01_0004);
      checkOutput("fetch_done_memEn",   memEnA,   0);
      ifReqA = 0;
      applyStimulus();
      checkOutput("fetch_idle_ifDone",  ifDoneA,  0);
      checkOutput("fetch_idle_busy",    busyA,    0);
      checkOutput("fetch_idle_memAddr", memAddrA, 32'h0000_0040);

      // Store 0xDEADBEEF to 0x1000; memory data must not be captured
      dmReqA = 1; dmWeA = 1; dmAddrA = 32'h0000_1000; dmWdataA = 32'hDEAD_BEEF;
      memRdataA = 32'h1234_5678;
      for (int i = 0; i < 3; i++) begin
         applyStimulus();
         checkOutput("store_memEn",    memEnA,    1);
         checkOutput("store_memWe",    memWeA,    1);
         checkOutput("store_memAddr",  memAddrA,  32'h0000_1000);
         checkOutput("store_memWdata", memWdataA, 32'hDEAD_BEEF);
         checkOutput("store_mdrLoad",  mdrLoadA,  0);
      end
      applyStimulus();
      checkOutput("store_done_dmDone",  dmDoneA,  1);
      checkOutput("store_done_ifDone",  ifDoneA,  0);
      checkOutput("store_done_memWe",   memWeA,   0);
      checkOutput("store_done_ifRdata", ifRdataA, 32'h8C01_0004);
      checkOutput("store_done_dmRdata", dmRdataA, 32'h0000_0000);
      dmReqA = 0; dmWeA = 0;
      applyStimulus();
      checkOutput("store_idle_dmDone", dmDoneA, 0);
      checkOutput("store_idle_busy",   busyA,   0);

      // Conflict: fetch 0x44 and load 0x2000 raised together and held
      ifReqA = 1; ifAddrA = 32'h0000_0044;
      dmReqA = 1; dmWeA = 0; dmAddrA = 32'h0000_2000;
      memRdataA = 32'h1111_2222;
      applyStimulus();
      checkOutput("conflict_first_memAddr", memAddrA,
                  firstDm ? 32'h0000_2000 : 32'h0000_0044);
      checkOutput("conflict_first_memWe", memWeA, 0);
      applyStimulus();
      applyStimulus();
      checkOutput("conflict_first_mdrLoad", mdrLoadA, 1);
      applyStimulus();
      checkOutput("conflict_first_dmDone", dmDoneA, 32'(firstDm));
      checkOutput("conflict_first_ifDone", ifDoneA, 32'(!firstDm));
      checkOutput("conflict_first_rdata", firstDm ? dmRdataA : ifRdataA, 32'h1111_2222);
      if (firstDm) dmReqA = 0;
      else         ifReqA = 0;
      memRdataA = 32'h3333_4444;
      applyStimulus();
      checkOutput("conflict_gap_busy",  busyA,  0);
      checkOutput("conflict_gap_memEn", memEnA, 0);
      applyStimulus();
      checkOutput("conflict_second_memEn",   memEnA, 1);
      checkOutput("conflict_second_memAddr", memAddrA,
                  firstDm ? 32'h0000_0044 : 32'h0000_2000);
      applyStimulus();
      applyStimulus();
      applyStimulus();
      checkOutput("conflict_second_dmDone", dmDoneA, 32'(!firstDm));
      checkOutput("conflict_second_ifDone", ifDoneA, 32'(firstDm));
      checkOutput("conflict_second_rdata", firstDm ? ifRdataA : dmRdataA, 32'h3333_4444);
      ifReqA = 0; dmReqA = 0;
      applyStimulus();
      checkOutput("conflict_end_busy", busyA, 0);
      checkOutput("conflict_end_firstRdata", firstDm ? dmRdataA : ifRdataA, 32'h1111_2222);

      // WAIT_CYCLES=0 load from 0x8 returning 5
      dmReqB = 1; dmWeB = 0; dmAddrB = 32'h0000_0008; memRdataB = 32'h0000_0005;
      applyStimulus();
      checkOutput("w0_memEn",   memEnB,   1);
      checkOutput("w0_mdrLoad", mdrLoadB, 1);
      checkOutput("w0_memAddr", memAddrB, 32'h0000_0008);
      applyStimulus();
      checkOutput("w0_dmDone",  dmDoneB,  1);
      checkOutput("w0_dmRdata", dmRdataB, 32'h0000_0005);
      checkOutput("w0_memEn_off", memEnB, 0);
      dmReqB = 0;
      applyStimulus();
      checkOutput("w0_idle_busy",   busyB,   0);
      checkOutput("w0_idle_dmDone", dmDoneB, 0);

      // Reset asserted in the second ACCESS cycle of a fetch
      ifReqA = 1; ifAddrA = 32'h0000_0100; memRdataA = 32'h0000_0077;
      applyStimulus();
      applyStimulus();
      checkOutput("rst_pre_memEn", memEnA, 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_async_busy",      busyA,     0);
      checkOutput("rst_async_memEn",     memEnA,    0);
      checkOutput("rst_async_memWe",     memWeA,    0);
      checkOutput("rst_async_mdrLoad",   mdrLoadA,  0);
      checkOutput("rst_async_ifDone",    ifDoneA,   0);
      checkOutput("rst_async_dmDone",    dmDoneA,   0);
      checkOutput("rst_async_memAddr",   memAddrA,  0);
      checkOutput("rst_async_memWdata",  memWdataA, 0);
      checkOutput("rst_async_ifRdata",   ifRdataA,  0);
      checkOutput("rst_async_dmRdata",   dmRdataA,  0);
      ifReqA = 0;
      #3 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         applyStimulus();
         checkOutput("rst_after_ifDone", ifDoneA, 0);
         checkOutput("rst_after_busy",   busyA,   0);
      end

      // Fresh fetch after reset completes normally
      ifReqA = 1; ifAddrA = 32'h0000_0200; memRdataA = 32'hABCD_0123;
      applyStimulus();
      checkOutput("post_rst_memEn",   memEnA,   1);
      checkOutput("post_rst_memAddr", memAddrA, 32'h0000_0200);
      applyStimulus();
      applyStimulus();
      checkOutput("post_rst_mdrLoad", mdrLoadA, 1);
      applyStimulus();
      checkOutput("post_rst_ifDone",  ifDoneA,  1);
      checkOutput("post_rst_ifRdata", ifRdataA, 32'hABCD_0123);
      ifReqA = 0;
      applyStimulus();
      checkOutput("post_rst_idle_busy", busyA, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences and shares the single unified memory port of the multicycle datapath between the instruction-fetch requester and the load/store requester. It drives the memory enable, address and write signals for a fixed number of wait cycles. On a read it strobes the memory data register and captures the returned word for the requester. It sits between the control unit's fetch and memory stages and the memory/MDR pair.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- WAIT_CYCLES, 2, extra memory cycles per access beyond the first (0..15)

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous and active-low
- if_req / if_addr  in  1 / ADDR_W  fetch request (read only) and address
- if_done / if_rdata  out  1 / DATA_W  one-cycle completion pulse and fetched word
- dm_req / dm_we  in  1 / 1  data request; 1 = store, 0 = load
- dm_addr / dm_wdata  in  ADDR_W / DATA_W  data address and store data
- dm_done / dm_rdata  out  1 / DATA_W  one-cycle completion pulse and loaded word
- mem_en / mem_we  out  1 / 1  memory access enable and write enable
- mem_addr / mem_wdata  out  ADDR_W / DATA_W  memory address and write data
- mem_rdata  in  DATA_W  memory read data, valid in the last access cycle
- mdr_load  out  1  memory data register capture strobe
- busy  out  1  high whenever the state is not IDLE

## Operation
- States:
  - IDLE: if any req is sampled high, select a winner, latch its addr/we/wdata and a grant flag, load the counter with WAIT_CYCLES, then go to ACCESS.
  - ACCESS: mem_en=1 and mem_* are driven from the latched values. Decrement the counter each cycle. In the cycle where the counter is 0, go to DONE.
  - DONE: pulse the winner's done for one cycle, then go to IDLE unconditionally.
- Read capture:
  - In the last ACCESS cycle of a read, mdr_load=1 and mem_rdata is registered into the winner's rdata register.
  - Each rdata register holds its value until that requester's next read completes.
  - Stores leave both rdata registers unchanged and never assert mdr_load.
- Arbitration: with both reqs sampled in IDLE, dm wins (see Configuration). A lone req always wins.
- Requester rules:
  - Hold req, addr, we and wdata stable from assertion until done.
  - Drop req in the cycle after done unless a new access is intended; a req still high in IDLE is a new request.
  - Inputs that change after the IDLE sample are ignored because they are latched.
- mem_we=0 outside ACCESS. mem_addr and mem_wdata hold the last latched values when mem_en=0.
- Reset values (asynchronous, mid-operation included): state IDLE, counter 0, mem_en/mem_we/mdr_load/if_done/dm_done/busy 0, mem_addr/mem_wdata/if_rdata/dm_rdata 0. Any access in flight is abandoned with no done.

## Timing
- Edge E samples req in IDLE. ACCESS occupies the cycles after edges E..E+WAIT_CYCLES.
- mem_rdata is captured at edge E+WAIT_CYCLES+1. done is high in the cycle after that edge.
- Rdata is valid in the same cycle as done.
- Throughput is one access per WAIT_CYCLES+3 cycles. Back-to-back requests always see one IDLE cycle.
- WAIT_CYCLES=0: ACCESS lasts exactly one cycle and mdr_load is high in that cycle.
- The counter is 4 bits wide and never underflows, because the exit happens at 0.

## Configuration
- MEM_ARB_RR_EN
  - Defined: round-robin arbitration using a 1-bit last-grant register. It is reset to "dm", so the first simultaneous conflict goes to if. After that, grants alternate on each conflict.
  - Undefined: fixed priority with dm over if. The last-grant register is not built.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (ST_IDLE, ST_ACCESS, ST_DONE)
  - the grant enum (GNT_IF, GNT_DM)
  - the counter width constant (4)
- Sub-module mem_wait_counter: a loadable down-counter with a zero flag, instantiated once.

## Test plan
- Fetch: WAIT_CYCLES=2, if_req with if_addr=0x0000_0040, memory returns 0x8C01_0004.
  - mem_en high for 3 cycles, mdr_load in the 3rd.
  - if_done 3 edges after the sample edge, with if_rdata=0x8C01_0004.
- Store: dm_req with dm_we=1, dm_addr=0x0000_1000, dm_wdata=0xDEAD_BEEF.
  - mem_we=1 for 3 cycles with matching addr/data.
  - dm_done pulses, no mdr_load, both rdata registers unchanged.
- Conflict: if_req and dm_req raised on the same edge, both held.
  - Fixed build: dm served, then if, with one IDLE cycle between.
  - RR build: if served first, then dm.
- WAIT_CYCLES=0 load from 0x0000_0008 returning 0x0000_0005: dm_done 1 edge after the sample edge, dm_rdata=0x5.
- Reset: rst_n low in the 2nd ACCESS cycle.
  - All outputs are 0 immediately (asynchronously).
  - After release the block is IDLE with no done, and a new fetch completes normally.
